// File: rtl/mru_replay.sv
// mru_replay: replays a captured MRU history (up to three LED indices) onto
// four one-hot LEDs. The most recent entry is shown first. Each entry is held
// for HOLD_TICKS cycles and followed by a one-cycle dark gap.
// Optional feature: define MRU_REPLAY_LOOP_EN to make the replay wrap and
// repeat until the next load or reset. Without it, the block returns to idle
// after one pass.
module mru_replay #(
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic        timedClk,
    input  logic        rst,
    input  logic [14:0] stack_in,
    input  logic        load,
    input  logic        start,
    input  logic        pop,
    output logic        l1,
    output logic        l2,
    output logic        l3,
    output logic        l4,
    output logic        busy,
    output logic        empty,
    output logic [1:0]  count
);

    localparam int unsigned SLOT_W = 5;
    localparam int unsigned LED_W  = 3;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned TICK_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // Last tick value of the SHOW phase before moving to the gap.
    localparam logic [TICK_W-1:0] TICK_LAST = 4'(HOLD_TICKS - 1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [LED_W-1:0]  buf_q [3];
    logic [LED_W-1:0]  buf_d [3];
    logic [1:0]        count_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;

    logic [SLOT_W-1:0] slot0;
    logic [SLOT_W-1:0] slot1;
    logic [SLOT_W-1:0] slot2;
    logic              ok0;
    logic              ok1;
    logic              ok2;
    logic [LED_W-1:0]  cap_buf [3];
    logic [1:0]        cap_count;
    logic              more_entries;
    logic [LED_W-1:0]  cur_led;

    assign slot0 = stack_in[4:0];
    assign slot1 = stack_in[9:5];
    assign slot2 = stack_in[14:10];

    // A slot counts only if it holds 1..4 and every more-recent slot also did.
    assign ok0 = (slot0 >= 5'd1) && (slot0 <= 5'd4);
    assign ok1 = ok0 && (slot1 >= 5'd1) && (slot1 <= 5'd4);
    assign ok2 = ok1 && (slot2 >= 5'd1) && (slot2 <= 5'd4);

    // Sanitised capture image and its leading-valid count.
    always_comb begin
        cap_buf[0] = '0;
        cap_buf[1] = '0;
        cap_buf[2] = '0;
        cap_count  = 2'd0;
        if (ok0) begin
            cap_buf[0] = slot0[LED_W-1:0];
            cap_count  = 2'd1;
        end
        if (ok1) begin
            cap_buf[1] = slot1[LED_W-1:0];
            cap_count  = 2'd2;
        end
        if (ok2) begin
            cap_buf[2] = slot2[LED_W-1:0];
            cap_count  = 2'd3;
        end
    end

    // Another entry remains after the current one. Widened by one bit so
    // idx+1 cannot wrap.
    assign more_entries = (3'({1'b0, idx_q}) + 3'd1) < 3'({1'b0, count});

    // Next-state logic. Load overrides everything; start/pop act only in idle.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        count_d = count;
        idx_d   = idx_q;
        tick_d  = tick_q;
        if (load) begin
            buf_d   = cap_buf;
            count_d = cap_count;
            idx_d   = '0;
            tick_d  = '0;
            state_d = (cap_count != 2'd0) ? SHOW : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count != 2'd0) begin
                            state_d = SHOW;
                            idx_d   = '0;
                            tick_d  = '0;
                        end
                    end else if (pop && (count != 2'd0)) begin
                        buf_d[0] = buf_q[1];
                        buf_d[1] = buf_q[2];
                        buf_d[2] = '0;
                        count_d  = count - 2'd1;
                    end
                end
                SHOW: begin
                    if (tick_q == TICK_LAST) begin
                        state_d = GAP;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                GAP: begin
                    tick_d = '0;
                    if (more_entries) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SHOW;
                    end else begin
`ifdef MRU_REPLAY_LOOP_EN
                        idx_d   = '0;
                        state_d = SHOW;
`else
                        idx_d   = '0;
                        state_d = IDLE;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    tick_d  = '0;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge timedClk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            buf_q[2] <= '0;
            count    <= 2'd0;
            idx_q    <= '0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            buf_q[2] <= buf_d[2];
            count    <= count_d;
            idx_q    <= idx_d;
            tick_q   <= tick_d;
        end
    end

    // Entry currently addressed by idx. The unused index value reads as empty.
    always_comb begin
        case (idx_q)
            2'd0:    cur_led = buf_q[0];
            2'd1:    cur_led = buf_q[1];
            2'd2:    cur_led = buf_q[2];
            default: cur_led = '0;
        endcase
    end

    // One-hot LED decode, lit only during SHOW.
    always_comb begin
        l1 = 1'b0;
        l2 = 1'b0;
        l3 = 1'b0;
        l4 = 1'b0;
        if (state_q == SHOW) begin
            case (cur_led)
                3'd1:    l1 = 1'b1;
                3'd2:    l2 = 1'b1;
                3'd3:    l3 = 1'b1;
                3'd4:    l4 = 1'b1;
                default: ;
            endcase
        end
    end

    // Status decodes of registered state.
    always_comb begin
        busy  = (state_q != IDLE);
        empty = (count == 2'd0);
    end

endmodule

// File: tb/tb_mru_replay.sv
// Testbench for mru_replay with HOLD_TICKS=2. The reference model keeps the
// retained history as a queue. Each replay is expanded into a per-cycle list
// of expected LED values.
module tb_mru_replay;

    localparam int unsigned HOLD = 2;

    logic        timedClk = 1'b0;
    logic        rst;
    logic [14:0] stack_in;
    logic        load;
    logic        start;
    logic        pop;
    logic        l1;
    logic        l2;
    logic        l3;
    logic        l4;
    logic        busy;
    logic        empty;
    logic [1:0]  count;

    int errors = 0;
    int checks = 0;
    int mq[$];
    int sched[$];

    mru_replay #(.HOLD_TICKS(HOLD)) dut (
        .timedClk(timedClk),
        .rst(rst),
        .stack_in(stack_in),
        .load(load),
        .start(start),
        .pop(pop),
        .l1(l1),
        .l2(l2),
        .l3(l3),
        .l4(l4),
        .busy(busy),
        .empty(empty),
        .count(count)
    );

    always #5 timedClk = ~timedClk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expand the retained history into per-cycle expected LED values.
    task automatic build_sched();
        sched.delete();
        foreach (mq[k]) begin
            repeat (HOLD) sched.push_back(mq[k]);
            sched.push_back(0);
        end
    endtask

    task automatic model_edge(input logic ld, input logic st, input logic pp, input logic [14:0] si);
        int s;
        s = int'(si);
        if (ld) begin
            mq.delete();
            for (int i = 0; i < 3; i++) begin
                int v;
                v = (s >> (5 * i)) & 31;
                if (v < 1 || v > 4) break;
                mq.push_back(v);
            end
            build_sched();
        end else if (sched.size() > 0) begin
            void'(sched.pop_front());
`ifdef MRU_REPLAY_LOOP_EN
            if (sched.size() == 0) build_sched();
`endif
        end else if (st) begin
            build_sched();
        end else if (pp && mq.size() > 0) begin
            void'(mq.pop_front());
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] leds;
        logic [3:0] exp_leds;
        leds = {l4, l3, l2, l1};
        exp_leds = 4'd0;
        if (sched.size() > 0 && sched[0] >= 1 && sched[0] <= 4)
            exp_leds = 4'(1 << (sched[0] - 1));
        chk({tag, "_leds"}, 8'(leds), 8'(exp_leds));
        chk({tag, "_busy"}, 8'(busy), 8'(sched.size() > 0));
        chk({tag, "_count"}, 8'(count), 8'(mq.size()));
        chk({tag, "_empty"}, 8'(empty), 8'(mq.size() == 0));
        chk({tag, "_onehot"}, 8'($countones(leds) <= 1), 8'd1);
    endtask

    task automatic cyc(input logic ld, input logic st, input logic pp, input logic [14:0] si,
                       input string tag);
        load = ld;
        start = st;
        pop = pp;
        stack_in = si;
        @(posedge timedClk);
        model_edge(ld, st, pp, si);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [14:0] si;
        rst = 1'b1;
        load = 1'b0;
        start = 1'b0;
        pop = 1'b0;
        stack_in = '0;
        #2;
        chk("reset_leds", 8'({l4, l3, l2, l1}), 8'd0);
        chk("reset_busy", 8'(busy), 8'd0);
        chk("reset_empty", 8'(empty), 8'd1);
        chk("reset_count", 8'(count), 8'd0);
        repeat (2) @(negedge timedClk);
        rst = 1'b0;
        cyc(0, 0, 0, 15'h0, "post_reset");

`ifndef MRU_REPLAY_LOOP_EN
        // Two-entry replay: l3 then l1, six cycles in all.
        cyc(1, 0, 0, 15'h0023, "r029_load");
        chk("r029_l3", 8'(l3), 8'd1);
        chk("r029_count", 8'(count), 8'd2);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 15'h0, "r029_run");
        chk("r029_idle", 8'(busy), 8'd0);

        // An invalid first slot empties the capture.
        cyc(1, 0, 0, 15'h0C05, "r030_load");
        chk("r030_count", 8'(count), 8'd0);
        chk("r030_empty", 8'(empty), 8'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 15'h0, "r030_idle");

        // Capture {2,4,1}, let it finish, pop, then replay {4,1}.
        cyc(1, 0, 0, 15'h0482, "r031_load");
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 15'h0, "r031_run");
        cyc(0, 0, 1, 15'h0, "r031_pop");
        chk("r031_count", 8'(count), 8'd2);
        cyc(0, 1, 0, 15'h0, "r031_start");
        chk("r031_l4", 8'(l4), 8'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 15'h0, "r031_run2");
        chk("r031_l1", 8'(l1), 8'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 15'h0, "r031_tail");
        chk("r031_done", 8'(busy), 8'd0);

        // load, start and pop together: load wins.
        cyc(1, 1, 1, 15'h0001, "r032_all");
        chk("r032_count", 8'(count), 8'd1);
        chk("r032_l1", 8'(l1), 8'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 15'h0, "r032_run");

        // Asynchronous reset during the second SHOW cycle.
        cyc(1, 0, 0, 15'h0023, "r033_load");
        cyc(0, 0, 0, 15'h0, "r033_show2");
        rst = 1'b1;
        #1;
        mq.delete();
        sched.delete();
        chk("r033_leds", 8'({l4, l3, l2, l1}), 8'd0);
        chk("r033_empty", 8'(empty), 8'd1);
        chk("r033_busy", 8'(busy), 8'd0);
        @(negedge timedClk);
        rst = 1'b0;
        cyc(0, 1, 0, 15'h0, "r033_start");
        chk("r033_stay_idle", 8'(busy), 8'd0);
`else
        // Looping replay of a single entry until a load with an empty stack.
        cyc(1, 0, 0, 15'h0002, "r034_load");
        for (int i = 0; i < 24; i++) cyc(0, i[0], i[1], 15'h0, "r034_loop");
        chk("r034_still_busy", 8'(busy), 8'd1);
        cyc(1, 0, 0, 15'h0000, "r034_stop");
        chk("r034_idle", 8'(busy), 8'd0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            si = '0;
            for (int k = 0; k < 3; k++) begin
                int v;
                v = int'($urandom_range(0, 6));
                if (v == 6) v = 31;
                si = si | 15'(v << (5 * k));
            end
            cyc(($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0, si, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
